// File: rtl/ledmatrix_frame_seq.sv
// MAX7219 command-word generator for N_DEV cascaded 8x8 modules: setup words, then
// 8 row words per frame (static / countdown / scroll), paced by a valid/ready handshake.
module ledmatrix_frame_seq #(
    parameter int          N_DEV      = 4,
    parameter logic [3:0]  INTENSITY  = 4'hF,
    parameter int          HOLD_TICKS = 100,
    parameter int          CD_START   = 10
) (
    input  logic                  clk_100Hz,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [8*N_DEV-1:0]    text_in,
    output logic [7:0]            glyph_char,
    output logic [2:0]            glyph_row,
    input  logic [7:0]            glyph_bits,
    output logic [16*N_DEV-1:0]   data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int WW = 8*N_DEV;
    localparam int DW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int SW = $clog2(2*N_DEV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [DW-1:0] DEV_LAST  = DW'(N_DEV-1);
    localparam logic [SW-1:0] SCR_LAST  = SW'(2*N_DEV-1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS-1);
    localparam logic [6:0]    CD_INIT   = 7'(CD_START);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_GLYPH, S_SEND, S_HOLD} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          set_idx_q, set_idx_d;
    logic [2:0]          row_q, row_d;
    logic [DW-1:0]       dev_q, dev_d;
    logic [WW-1:0]       win_q, win_d;
    logic [16*N_DEV-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                fdone_q, fdone_d;
    logic                last_q, last_d;
    logic [6:0]          cd_q, cd_d;
    logic [SW-1:0]       scr_q, scr_d;
    logic [HW-1:0]       hold_q, hold_d;

    function automatic logic [15:0] setup_word(input logic [2:0] i);
        case (i)
            3'd0:    return 16'h0900;
            3'd1:    return {12'h0A0, INTENSITY};
            3'd2:    return 16'h0B07;
            3'd3:    return 16'h0C01;
            default: return 16'h0F00;
        endcase
    endfunction

    // Countdown digits land in the two rightmost slots; a zero tens digit is blanked.
    logic [6:0]          tens, units;
    logic [7:0]          tens_c, unit_c;
    logic [WW-1:0]       cd_win, sc_win;
    logic [32*N_DEV-1:0] dbl;

    always_comb begin
        tens   = cd_q / 7'd10;
        units  = cd_q % 7'd10;
        tens_c = (tens == 7'd0) ? 8'h00 : 8'h30 + {1'b0, tens};
        unit_c = 8'h30 + {1'b0, units};
        cd_win = WW'({tens_c, unit_c});
        // Circular view of {text, blanks}: doubling the sequence makes the wrap a plain shift.
        dbl    = {text_in, {WW{1'b0}}, text_in, {WW{1'b0}}} << {scr_q, 3'b000};
        sc_win = dbl[32*N_DEV-1 -: WW];
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            set_idx_q <= '0;
            row_q     <= '0;
            dev_q     <= '0;
            win_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            last_q    <= 1'b0;
            cd_q      <= '0;
            scr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            set_idx_q <= set_idx_d;
            row_q     <= row_d;
            dev_q     <= dev_d;
            win_q     <= win_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
            last_q    <= last_d;
            cd_q      <= cd_d;
            scr_q     <= scr_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        set_idx_d  = set_idx_q;
        row_d      = row_q;
        dev_d      = dev_q;
        win_d      = win_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        fdone_d    = 1'b0;
        last_d     = last_q;
        cd_d       = cd_q;
        scr_d      = scr_q;
        hold_d     = hold_q;
        glyph_char = '0;
        glyph_row  = '0;
        case (state_q)
            S_IDLE: if (start) begin
                mode_d    = mode;
                busy_d    = 1'b1;
                cd_d      = CD_INIT;
                scr_d     = '0;
                set_idx_d = '0;
                data_d    = {N_DEV{setup_word(3'd0)}};
                valid_d   = 1'b1;
                state_d   = S_SETUP;
            end
            S_SETUP: if (data_ready) begin
                if (set_idx_q == 3'd4) begin
                    valid_d = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    set_idx_d = set_idx_q + 3'd1;
                    data_d    = {N_DEV{setup_word(set_idx_q + 3'd1)}};
                end
            end
            S_LOAD: begin
                case (mode_q)
                    2'd1: begin
                        win_d  = (cd_q == 7'd0) ? '0 : cd_win;
                        last_d = (cd_q == 7'd0);
                    end
                    2'd2: begin
                        win_d  = sc_win;
                        last_d = 1'b0;
                    end
                    default: begin
                        win_d  = text_in;
                        last_d = 1'b1;
                    end
                endcase
                dev_d   = DEV_LAST;
                row_d   = '0;
                state_d = S_GLYPH;
            end
            S_GLYPH: begin
                glyph_char = win_q[{dev_q, 3'b000} +: 8];
                glyph_row  = row_q;
                data_d[{dev_q, 4'b0000} +: 16] = {4'h0, {1'b0, row_q} + 4'd1, glyph_bits};
                if (dev_q == '0) begin
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end else begin
                    dev_d = dev_q - 1'b1;
                end
            end
            S_SEND: if (data_ready) begin
                valid_d = 1'b0;
                if (row_q == 3'd7) begin
                    fdone_d = 1'b1;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    row_d   = row_q + 3'd1;
                    dev_d   = DEV_LAST;
                    state_d = S_GLYPH;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    if (last_q) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        if (mode_q == 2'd1) cd_d = cd_q - 7'd1;
                        if (mode_q == 2'd2) scr_d = (scr_q == SCR_LAST) ? '0 : scr_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_done = fdone_q;
endmodule
